// File: rtl/rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_arbiter_pkg
// Shared constants, types and helpers for the N-channel round-robin arbiter.
//   N_CH_DEF       default channel count
//   DATA_WIDTH_DEF default payload width
//   idx_w(n)       width of an index able to address n channels (min 1)
//   grant_idx_t    grant index type for the default channel count
// ----------------------------------------------------------------------------
package rr_arbiter_pkg;

   localparam int unsigned N_CH_DEF       = 4;
   localparam int unsigned DATA_WIDTH_DEF = 16;

   function automatic int unsigned idx_w(input int unsigned n);
      if (n <= 2) begin
         return 1;
      end
      return $clog2(n);
   endfunction

   typedef logic [idx_w(N_CH_DEF)-1:0] grant_idx_t;

endpackage

// File: rtl/rr_arbiter_prio.sv
// ----------------------------------------------------------------------------
// rr_arbiter_prio
// Combinational rotating-priority picker. Searches ptr+1, ptr+2, ... (mod
// N_CH) for the first asserted request.
//   req_i        per-channel requests
//   ptr_i        index of the last granted channel
//   gnt_onehot_o one-hot winner (zero when no request)
//   gnt_idx_o    winner index (zero when no request)
//   any_o        at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter_prio
   import rr_arbiter_pkg::*;
#(
   parameter int unsigned N_CH  = N_CH_DEF,
   parameter int unsigned IDX_W = idx_w(N_CH_DEF)
) (
   input  logic [N_CH-1:0]  req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_CH-1:0]  gnt_onehot_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             any_o
);

   logic [N_CH-1:0]   mask;
   logic [2*N_CH-1:0] dbl;
   logic              found;

   // Lower half holds only requests above ptr; upper half holds all requests,
   // so the first set bit of the doubled vector is the rotating winner.
   always_comb begin
      mask = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         mask[i] = (i > int'(ptr_i));
      end
      dbl          = {req_i, req_i & mask};
      any_o        = |req_i;
      gnt_onehot_o = '0;
      gnt_idx_o    = '0;
      found        = 1'b0;
      for (int i = 0; i < int'(2 * N_CH); i++) begin
         if (!found && dbl[i]) begin
            found                       = 1'b1;
            gnt_onehot_o[i % int'(N_CH)] = 1'b1;
            gnt_idx_o                   = IDX_W'(i % int'(N_CH));
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_n.sv
// ----------------------------------------------------------------------------
// rr_arbiter_n
// N-channel round-robin arbiter with valid/ready per channel and a registered
// output stage. Optional packet lock is enabled with macro RR_ARB_LOCK_EN.
//   aclk      clock, rising edge
//   areset_n  asynchronous active-low reset
//   valid_i   per-channel valid
//   data_i    per-channel payload (packed)
//   ready_o   per-channel accept, one-hot or zero
//   valid_o   output register holds a beat
//   data_o    registered payload
//   grant_o   channel index that supplied data_o
//   ready_i   downstream accept
//   last_i    per-channel end-of-packet (RR_ARB_LOCK_EN only)
// ----------------------------------------------------------------------------
module rr_arbiter_n
   import rr_arbiter_pkg::*;
#(
   parameter int unsigned N_CH       = N_CH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                             aclk,
   input  logic                             areset_n,
   input  logic [N_CH-1:0]                  valid_i,
   input  logic [N_CH-1:0][DATA_WIDTH-1:0]  data_i,
   output logic [N_CH-1:0]                  ready_o,
   output logic                             valid_o,
   output logic [DATA_WIDTH-1:0]            data_o,
   output logic [idx_w(N_CH)-1:0]           grant_o,
`ifdef RR_ARB_LOCK_EN
   input  logic [N_CH-1:0]                  last_i,
`endif
   input  logic                             ready_i
);

   localparam int unsigned IDX_W = idx_w(N_CH);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [IDX_W-1:0]      grant_q, grant_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;

   logic [N_CH-1:0]       req_eff;
   logic [N_CH-1:0]       gnt_onehot;
   logic [IDX_W-1:0]      gnt_idx;
   logic                  any;
   logic                  load;
   logic                  xfer;

`ifdef RR_ARB_LOCK_EN
   logic                  lock_q, lock_d;
   logic [IDX_W-1:0]      lock_idx_q, lock_idx_d;
`endif

   // While a packet is locked only its owner may compete.
   always_comb begin
      req_eff = valid_i;
`ifdef RR_ARB_LOCK_EN
      if (lock_q) begin
         req_eff             = '0;
         req_eff[lock_idx_q] = valid_i[lock_idx_q];
      end
`endif
   end

   rr_arbiter_prio #(
      .N_CH  (N_CH),
      .IDX_W (IDX_W)
   ) u_prio (
      .req_i        (req_eff),
      .ptr_i        (ptr_q),
      .gnt_onehot_o (gnt_onehot),
      .gnt_idx_o    (gnt_idx),
      .any_o        (any)
   );

   assign load = ~valid_q | ready_i;
   assign xfer = load & any;

   // Reset gates ready_o so upstream never sees an accept while held in reset.
   always_comb begin
      ready_o = '0;
      if (load && areset_n) begin
         ready_o = gnt_onehot;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if (load) begin
         valid_d = any;
      end
      if (xfer) begin
         data_d  = data_i[gnt_idx];
         grant_d = gnt_idx;
         ptr_d   = gnt_idx;
      end
   end

`ifdef RR_ARB_LOCK_EN
   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (xfer) begin
         lock_d     = ~last_i[gnt_idx];
         lock_idx_d = gnt_idx;
      end
   end
`endif

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         valid_q    <= 1'b0;
         data_q     <= '0;
         grant_q    <= '0;
         ptr_q      <= IDX_W'(N_CH - 1);
`ifdef RR_ARB_LOCK_EN
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
`endif
      end else begin
         valid_q    <= valid_d;
         data_q     <= data_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
`ifdef RR_ARB_LOCK_EN
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
`endif
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign grant_o = grant_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter_n
// Directed bench for rr_arbiter_n (N_CH=4, DATA_WIDTH=16). Expected beats go
// into a queue as stimulus is issued; a negedge monitor pops and compares each
// beat the downstream accepts. Honours RR_ARB_LOCK_EN.
// ----------------------------------------------------------------------------
module tb_rr_arbiter_n;
   import rr_arbiter_pkg::*;

   typedef struct {
      grant_idx_t  g;
      logic [15:0] d;
   } beat_t;

   logic                  aclk;
   logic                  areset_n;
   logic [3:0]            valid_i;
   logic [3:0][15:0]      data_i;
   logic [3:0]            ready_o;
   logic                  valid_o;
   logic [15:0]           data_o;
   grant_idx_t            grant_o;
   logic                  ready_i;
`ifdef RR_ARB_LOCK_EN
   logic [3:0]            last_i;
`endif

   logic [15:0] pay [4];
   beat_t       exp_q[$];
   int          n_checks;
   int          n_err;

   rr_arbiter_n #(
      .N_CH       (4),
      .DATA_WIDTH (16)
   ) dut (
      .aclk     (aclk),
      .areset_n (areset_n),
      .valid_i  (valid_i),
      .data_i   (data_i),
      .ready_o  (ready_o),
      .valid_o  (valid_o),
      .data_o   (data_o),
      .grant_o  (grant_o),
`ifdef RR_ARB_LOCK_EN
      .last_i   (last_i),
`endif
      .ready_i  (ready_i)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Scoreboard monitor: a beat is consumed when valid_o & ready_i hold.
   always @(negedge aclk) begin
      if (areset_n && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(grant_o), 32'hFFFF_FFFF);
         end else begin
            beat_t e;
            e = exp_q.pop_front();
            chk("beat_grant", 32'(grant_o), 32'(e.g));
            chk("beat_data", 32'(data_o), 32'(e.d));
         end
      end
   end

   // All tasks start and end at posedge+1.
   task automatic beat(input logic [3:0] v, input int g);
      beat_t      e;
      logic [3:0] oh;
      valid_i = v;
      ready_i = 1'b1;
      #2;
      oh = 4'b0001 << g;
      chk("ready_onehot", 32'(ready_o), 32'(oh));
      e.g = grant_idx_t'(g);
      e.d = pay[g];
      exp_q.push_back(e);
      @(posedge aclk);
      #1;
   endtask

   task automatic idle();
      valid_i = 4'b0000;
      ready_i = 1'b1;
      #2;
      chk("ready_idle", 32'(ready_o), 32'h0);
      @(posedge aclk);
      #1;
   endtask

   task automatic frozen(input int g);
      valid_i = 4'b1111;
      ready_i = 1'b0;
      #2;
      chk("freeze_ready", 32'(ready_o), 32'h0);
      chk("freeze_valid", 32'(valid_o), 32'h1);
      chk("freeze_grant", 32'(grant_o), 32'(g));
      chk("freeze_data", 32'(data_o), 32'(pay[g]));
      @(posedge aclk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      pay[0] = 16'hAAAA;
      pay[1] = 16'hBBBB;
      pay[2] = 16'hCCCC;
      pay[3] = 16'hDDDD;
      for (int c = 0; c < 4; c++) data_i[c] = pay[c];
      areset_n = 1'b0;
      valid_i  = 4'b0000;
      ready_i  = 1'b0;
`ifdef RR_ARB_LOCK_EN
      last_i   = 4'b1111;
`endif
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_valid", 32'(valid_o), 32'h0);
      chk("rst_data", 32'(data_o), 32'h0);
      chk("rst_grant", 32'(grant_o), 32'h0);
      chk("rst_ready", 32'(ready_o), 32'h0);
      areset_n = 1'b1;

      // 1: all request, full rotation from channel 0
      beat(4'b1111, 0);
      beat(4'b1111, 1);
      beat(4'b1111, 2);
      beat(4'b1111, 3);
      beat(4'b1111, 0);
      beat(4'b1111, 1);
      idle();

      // 2: sole requester repeats, then ch3 and ch0 via wrap
      for (int k = 0; k < 5; k++) beat(4'b0100, 2);
      beat(4'b1001, 3);
      beat(4'b1001, 0);
      idle();

      // 3: backpressure freezes grant 1, then rotation resumes at 2
      beat(4'b1111, 1);
      for (int k = 0; k < 4; k++) frozen(1);
      beat(4'b1111, 2);
      beat(4'b1111, 3);
      idle();

      // 4: ptr=3, ch1 and ch3 requesting
      beat(4'b1010, 1);
      beat(4'b1010, 3);
      idle();

      // 5: reset while a beat is held
      valid_i = 4'b0100;
      ready_i = 1'b0;
      #2;
      chk("pre_rst_ready", 32'(ready_o), 32'b0100);
      @(posedge aclk);
      #1;
      valid_i = 4'b0000;
      #2;
      chk("held_valid", 32'(valid_o), 32'h1);
      chk("held_grant", 32'(grant_o), 32'h2);
      #2;
      areset_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(valid_o), 32'h0);
      chk("midrst_data", 32'(data_o), 32'h0);
      chk("midrst_grant", 32'(grant_o), 32'h0);
      valid_i = 4'b1111;
      #1;
      chk("midrst_ready", 32'(ready_o), 32'h0);
      @(posedge aclk);
      #1;
      areset_n = 1'b1;
      beat(4'b1111, 0);
      idle();

      // 6: ch0 three-beat packet while ch1 requests (ptr=3 first)
`ifdef RR_ARB_LOCK_EN
      last_i = 4'b1111;
      beat(4'b1000, 3);
      last_i = 4'b0010;
      beat(4'b0011, 0);
      valid_i = 4'b0010;
      ready_i = 1'b1;
      #2;
      chk("lock_blocks_other", 32'(ready_o), 32'h0);
      @(posedge aclk);
      #1;
      beat(4'b0011, 0);
      last_i = 4'b0011;
      beat(4'b0011, 0);
      beat(4'b0011, 1);
`else
      beat(4'b1000, 3);
      beat(4'b0011, 0);
      beat(4'b0011, 1);
      beat(4'b0011, 0);
      beat(4'b0011, 1);
`endif
      idle();
      idle();

      chk("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_n.md
Name: rr_arbiter_n

Overview:
N-channel round-robin arbiter with per-channel valid/ready handshake and a registered output stage.
- Parametrised successor of the team's two-input arbiter: generalises channel count and width, and adds backpressure plus grant-index reporting.
- Sits between multiple producers and one shared downstream consumer.
- Fair rotation guarantees each continuously requesting channel one beat per N accepted beats.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DATA_WIDTH, 16, payload width in bits.
- IDX_W, $clog2(N_CH), width of the grant index (derived localparam, not overridable).

Ports:
- aclk  input  1  single clock, rising edge.
- areset_n  input  1  asynchronous, active-low reset.
- valid_i  input  N_CH  per-channel request/valid.
- data_i  input  N_CH x DATA_WIDTH  per-channel payload (packed array).
- ready_o  output  N_CH  per-channel accept; one-hot or zero.
- valid_o  output  1  output register holds a beat.
- data_o  output  DATA_WIDTH  registered payload.
- grant_o  output  IDX_W  index of the channel that supplied data_o.
- ready_i  input  1  downstream accept.
- last_i  input  N_CH  end-of-packet flag per channel; present only with RR_ARB_LOCK_EN.

Behaviour:
- Reset (async assert, sync release): valid_o=0, data_o=0, grant_o=0, last-grant pointer=N_CH-1, so channel 0 has top priority first.
- Load enable: load = ~valid_o | ready_i. The output stage accepts a new beat while empty or while draining in the same cycle.
- Winner selection: first asserted valid_i found by searching ptr+1, ptr+2, ... modulo N_CH. Purely combinational from the registered pointer.
- ready_o[w] = load & valid_i[w] for the winner w only. All other ready_o bits are 0. ready_o is 0 for every channel when no valid_i is set.
- Transfer on channel w happens when valid_i[w] & ready_o[w]. On that edge:
  - data_o <= data_i[w]
  - grant_o <= w
  - valid_o <= 1
  - ptr <= w
- Latency: 1 cycle from input handshake to valid_o.
- Throughput: 1 beat per cycle when ready_i is held at 1.
- Drain without refill: valid_o & ready_i with no valid_i set gives valid_o <= 0. data_o and grant_o hold their last values.
- Backpressure: valid_o & ~ready_i freezes data_o, grant_o and ptr. All ready_o are 0.
- Pointer moves only on an accepted transfer. Requests that are withdrawn never alter fairness.
- Wrap-around: the search wraps from index N_CH-1 to 0. With ptr=N_CH-1, channel 0 is checked first.
- Sole requester: that channel is granted every eligible cycle, including back-to-back repeats of the same index.
- Producers must hold valid_i and data_i stable until ready_o is seen. The arbiter does not check this.
- Reset asserted mid-transfer: the output beat is dropped and the pointer returns to N_CH-1. Upstream sees no ready_o while reset is low.

Optional Feature:
RR_ARB_LOCK_EN
- Defined:
  - Adds the last_i port and a lock register (lock flag plus locked index).
  - A transfer from channel w with last_i[w]=0 sets the lock on w.
  - While locked, only channel w may win; other requests are ignored even if w is idle.
  - A transfer with last_i[w]=1 clears the lock. The pointer advances to w as normal.
  - The lock resets to clear.
  - A single-beat packet (last_i=1 on the first beat) never locks.
- Undefined: last_i does not exist. Arbitration rotates per beat.

Decomposition:
- Package rr_arbiter_pkg holds:
  - the default N_CH and DATA_WIDTH constants;
  - the function idx_w(n) for index width;
  - the typedef for the grant index.
- One sub-module, rr_arbiter_prio: combinational rotating priority picker.
  - Inputs: req[N_CH], ptr[IDX_W].
  - Outputs: gnt_onehot[N_CH], gnt_idx[IDX_W], any.
  - Implemented as a double-width masked priority encode.
- rr_arbiter_n contains the pointer, the output register and the optional lock logic.

Test Plan:
1. Reset, N_CH=4, all valid_i=1, ready_i=1 -> grant_o sequence 0,1,2,3,0,1; one beat per cycle; data_o matches the granted channel (e.g. 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD).
2. Only ch2 valid for 5 cycles, ready_i=1 -> 5 consecutive beats with grant_o=2. Then assert ch0 and ch3 -> next grants 3, then 0.
3. valid_o=1 and ready_i=0 for 4 cycles with all channels requesting -> data_o/grant_o frozen and ready_o=0000. Release -> rotation resumes from the frozen grant+1.
4. ch1 and ch3 valid, ptr=3 after reset activity -> ch1 wins. Then ch3. Pointer wrap covered.
5. Assert areset_n=0 while valid_o=1 -> valid_o=0 and data_o=0 immediately. After release, channel 0 is granted first.
6. With RR_ARB_LOCK_EN: ch0 sends a 3-beat packet (last on beat 3) while ch1 requests throughout -> grants 0,0,0,1. With the macro undefined, the same stimulus gives 0,1,0,1.
